// File: rtl/encode164_stream.sv
// ============================================================================
// encode164_stream : serialises a 16-line request vector into ascending
// 4-bit indices over valid/ready handshakes.            Rev 1.0
// ============================================================================
`default_nettype none

module encode164_stream (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [0:15] in_vec,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [0:3]  out_idx,
   output logic        out_last,
   output logic        empty,
   output logic [0:4]  count
);

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [0:15] pending_q, pending_d;
   logic [0:4]  count_q, count_d;
   logic        empty_q, empty_d;

   logic [0:3]  low_idx;
   logic        one_hot;
   logic [0:4]  in_pop;
   logic        xfer;

   // Lowest set line wins: scanning high-to-low leaves the smallest index.
   always_comb begin
      low_idx = 4'd0;
      for (int k = 15; k >= 0; k--) begin
         if (pending_q[k]) low_idx = 4'(k);
      end
   end

   always_comb begin
      in_pop = 5'd0;
      for (int k = 0; k < 16; k++) begin
         in_pop = in_pop + {4'd0, in_vec[k]};
      end
   end

   assign one_hot   = (pending_q != 16'd0) && ((pending_q & (pending_q - 16'd1)) == 16'd0);
   assign out_valid = (state_q == EMIT);
   assign in_ready  = (state_q == IDLE);
   assign out_idx   = low_idx;
   assign out_last  = out_valid && one_hot;
   assign empty     = empty_q;
   assign count     = count_q;
   assign xfer      = out_valid && out_ready;

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      count_d   = count_q;
      empty_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (in_vec != 16'd0) begin
                  pending_d = in_vec;
                  count_d   = in_pop;
                  state_d   = EMIT;
               end else begin
                  empty_d = 1'b1;
               end
            end
         end
         EMIT: begin
            if (xfer) begin
               pending_d[low_idx] = 1'b0;
               if (one_hot) begin
                  count_d = 5'd0;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pending_q <= 16'd0;
         count_q   <= 5'd0;
         empty_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         count_q   <= count_d;
         empty_q   <= empty_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_encode164_stream.sv
// ============================================================================
// tb_encode164_stream : directed self-checking bench for encode164_stream.
// ============================================================================
`default_nettype none

module tb_encode164_stream;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [0:15] in_vec;
   logic        out_valid;
   logic        out_ready;
   logic [0:3]  out_idx;
   logic        out_last;
   logic        empty;
   logic [0:4]  count;

   int checks = 0;
   int errors = 0;

   encode164_stream dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vec    (in_vec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .empty     (empty),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one vector for a single accepting edge; returns at #1 after it.
   task automatic send(input logic [0:15] v);
      for (int i = 0; i < 20 && !in_ready; i++) step();
      chk("send_ready", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_vec   = v;
      step();
      in_valid = 1'b0;
      in_vec   = 16'd0;
   endtask

   task automatic chk_out(input string tag, input int idx, input bit last, input int cnt);
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_idx"},   {28'd0, out_idx},   32'(idx));
      chk({tag, "_last"},  {31'd0, out_last},  {31'd0, last});
      chk({tag, "_count"}, {27'd0, count},     32'(cnt));
      chk({tag, "_inrdy"}, {31'd0, in_ready},  32'd0);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_inrdy"}, {31'd0, in_ready},  32'd1);
      chk({tag, "_count"}, {27'd0, count},     32'd0);
   endtask

   initial begin
      logic [0:15] v;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_vec    = 16'd0;
      out_ready = 1'b1;
      #3;
      chk("rst_inrdy", {31'd0, in_ready},  32'd1);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_idx",   {28'd0, out_idx},   32'd0);
      chk("rst_last",  {31'd0, out_last},  32'd0);
      chk("rst_empty", {31'd0, empty},     32'd0);
      chk("rst_count", {27'd0, count},     32'd0);
      step();
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Single line 5
      v = 16'd0; v[5] = 1'b1;
      send(v);
      chk_out("single", 5, 1'b1, 1);
      step();
      chk_idle("single_done");

      // Lines {0,3,15} with a stall on the first index
      out_ready = 1'b0;
      v = 16'd0; v[0] = 1'b1; v[3] = 1'b1; v[15] = 1'b1;
      send(v);
      chk_out("multi_first", 0, 1'b0, 3);
      for (int i = 0; i < 3; i++) begin
         step();
         chk_out("multi_stall", 0, 1'b0, 3);
      end
      out_ready = 1'b1;
      step();
      chk_out("multi_second", 3, 1'b0, 3);
      step();
      chk_out("multi_third", 15, 1'b1, 3);
      step();
      chk_idle("multi_done");

      // All lines
      send(16'hFFFF);
      for (int i = 0; i < 16; i++) begin
         chk_out("all", i, (i == 15), 16);
         step();
      end
      chk_idle("all_done");

      // Zero vector
      send(16'd0);
      chk("zero_empty", {31'd0, empty}, 32'd1);
      chk_idle("zero_cyc1");
      step();
      chk("zero_empty2", {31'd0, empty}, 32'd0);
      chk_idle("zero_cyc2");

      // Busy ignore: {4} offered while emitting {2,9}
      v = 16'd0; v[2] = 1'b1; v[9] = 1'b1;
      send(v);
      chk_out("busy_first", 2, 1'b0, 2);
      v = 16'd0; v[4] = 1'b1;
      in_valid = 1'b1;
      in_vec   = v;
      step();
      chk_out("busy_second", 9, 1'b1, 2);
      step();
      in_valid = 1'b0;
      in_vec   = 16'd0;
      chk_idle("busy_done");
      send(v);
      chk_out("busy_fresh", 4, 1'b1, 1);
      step();
      chk_idle("busy_fresh_done");

      // Reset mid-burst after index 1 transfers
      v = 16'd0; v[1] = 1'b1; v[6] = 1'b1; v[11] = 1'b1;
      send(v);
      chk_out("rstb_first", 1, 1'b0, 3);
      step();
      chk_out("rstb_second", 6, 1'b0, 3);
      rst_n = 1'b0;
      #1;
      chk_idle("rstb_abort");
      step();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_idle("rstb_after");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
